dist_ram_arbiter: RTL and testbench

Two-port request arbiter and sequencer in front of the synchronous distributed RAM (32-bit data, 64 words, registered `qspo` output with clock-enable and sync reset). It shares the single RAM port between a core data port (P0) and a loader/debug port (P1) using round-robin arbitration. It drives the RAM's address, data, write-enable, output-enable and output-reset pins, and returns read data with a fixed one-cycle latency. An optional post-reset clear sweep zeroes the array before any requester is served.

---
 rtl/rvp_ram_pkg.sv | 9 +
 rtl/dist_ram_arbiter_rr_arb2.sv | 13 +
 rtl/dist_ram_arbiter.sv | 91 +++++++++
 tb/tb_dist_ram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rvp_ram_pkg.sv
// rvp_ram_pkg: shared defaults, FSM state encoding and port IDs for the RAM arbiter
package rvp_ram_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 64;
  typedef enum logic {CLEAR, SERVE} state_t;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/dist_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant generator; the port other than last wins a tie
module rr_arb2
  import rvp_ram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       last_nxt
);
  assign gnt[0] = req[0] & (~req[1] | (last == P1));
  assign gnt[1] = req[1] & (~req[0] | (last == P0));
  assign last_nxt = &req ? (gnt[1] ? P1 : P0) : last;
endmodule

// File: rtl/dist_ram_arbiter.sv
// dist_ram_arbiter: round-robin sharing of one distributed RAM port between P0 and P1; RVP_RAM_CLEAR_EN adds a post-reset zero sweep
module dist_ram_arbiter
  import rvp_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic              ram_qspo_ce,
  output logic              ram_qspo_srst,
  input  logic [DATA_W-1:0] ram_qspo,
  output logic              busy
);
  state_t state, state_nxt;
  logic [1:0] req, gnt;
  logic last, last_nxt, serve;
  logic [ADDR_W-1:0] sweep_a;
`ifdef RVP_RAM_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  logic [ADDR_W-1:0] cnt;
  // sweep counter: restarts at 0 on reset, idles at 0 once serving
  always_ff @(posedge clk)
    cnt <= (!srst_n || serve) ? '0 : cnt + 1'b1;
  // leave CLEAR after the last word has been zeroed
  always_comb
    state_nxt = (!serve && cnt == ADDR_W'(DEPTH - 1)) ? SERVE : state;
  assign sweep_a = cnt;
  assign busy = ~serve;
`else
  localparam state_t RST_STATE = SERVE;
  // without the sweep the FSM never leaves SERVE
  always_comb
    state_nxt = SERVE;
  assign sweep_a = '0;
  assign busy = 1'b0;
`endif
  assign serve = (state == SERVE);
  assign req = {p1_req, p0_req} & {2{serve}};
  rr_arb2 u_arb (
    .req(req),
    .last(last),
    .gnt(gnt),
    .last_nxt(last_nxt)
  );
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];
  assign p0_rdata = ram_qspo;
  assign p1_rdata = ram_qspo;
  assign ram_qspo_srst = ~srst_n;
  // state register
  always_ff @(posedge clk)
    state <= !srst_n ? RST_STATE : state_nxt;
  // RAM pin mux: sweep writes zeros, otherwise the winner (P0 when idle) drives the port
  always_comb begin
    ram_a = !serve ? sweep_a : gnt[1] ? p1_addr : p0_addr;
    ram_d = !serve ? '0 : gnt[1] ? p1_wdata : p0_wdata;
    ram_we = ~serve | (gnt[0] & p0_we) | (gnt[1] & p1_we);
    ram_qspo_ce = (gnt[0] & ~p0_we) | (gnt[1] & ~p1_we);
  end
  // round-robin pointer and one-cycle read-valid pulses
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      last <= P1;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      last <= last_nxt;
      p0_rvalid <= gnt[0] & ~p0_we;
      p1_rvalid <= gnt[1] & ~p1_we;
    end
  end
endmodule

// File: tb/tb_dist_ram_arbiter.sv
// tb_dist_ram_arbiter: randomized and directed checks of dist_ram_arbiter against a behavioural RAM/arbiter model
module tb_dist_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEP = 64;
`ifdef RVP_RAM_CLEAR_EN
  localparam int CLR = DEP;
`else
  localparam int CLR = 0;
`endif
  logic clk = 1'b0;
  logic srst_n;
  logic p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic ram_we, ram_qspo_ce, ram_qspo_srst, busy;
  logic [DW-1:0] ram_qspo;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_ref [DEP];
  bit last_ref;
  int clr_left, sw_addr;
  bit rv0, rv1, g0, g1;
  logic [DW-1:0] rd0, rd1;
  logic [DW-1:0] ram [DEP];
  logic loaded = 1'b0;

  always #5 clk = ~clk;

  dist_ram_arbiter dut (
    .clk(clk), .srst_n(srst_n),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_qspo_ce(ram_qspo_ce),
    .ram_qspo_srst(ram_qspo_srst), .ram_qspo(ram_qspo), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // distributed RAM with registered qspo output
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEP; i++) ram[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (ram_we) ram[ram_a] <= ram_d;
    if (ram_qspo_srst) ram_qspo <= '0;
    else if (ram_qspo_ce) ram_qspo <= ram[ram_a];
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock cycle: compare at negedge against the model, then advance the model
  task automatic cycle();
    bit w, we, n0, n1;
    logic [AW-1:0] a;
    logic [DW-1:0] d, nd;
    @(negedge clk);
    g0 = 0;
    g1 = 0;
    if (clr_left == 0) begin
      if (p0_req && p1_req) begin
        g0 = last_ref;
        g1 = !last_ref;
      end else begin
        g0 = p0_req;
        g1 = p1_req;
      end
    end
    check("p0_gnt", p0_gnt, g0);
    check("p1_gnt", p1_gnt, g1);
    check("busy", busy, clr_left != 0);
    check("qspo_srst", ram_qspo_srst, !srst_n);
    check("p0_rvalid", p0_rvalid, rv0);
    check("p1_rvalid", p1_rvalid, rv1);
    if (rv0) check("p0_rdata", p0_rdata, rd0);
    if (rv1) check("p1_rdata", p1_rdata, rd1);
    w = g1;
    we = w ? p1_we : p0_we;
    a = w ? p1_addr : p0_addr;
    d = w ? p1_wdata : p0_wdata;
    n0 = 0;
    n1 = 0;
    nd = '0;
    if (clr_left != 0) begin
      check("sweep_we", ram_we, 1);
      check("sweep_a", ram_a, sw_addr);
      check("sweep_d", ram_d, 0);
      check("sweep_ce", ram_qspo_ce, 0);
      mem_ref[sw_addr] = '0;
      sw_addr = (sw_addr + 1) % DEP;
      clr_left--;
    end else if (g0 || g1) begin
      check("ram_a", ram_a, a);
      check("ram_we", ram_we, we);
      check("ram_ce", ram_qspo_ce, !we);
      if (we) begin
        check("ram_d", ram_d, d);
        mem_ref[a] = d;
      end else begin
        nd = mem_ref[a];
        if (w) n1 = 1; else n0 = 1;
      end
      if (p0_req && p1_req) last_ref = g1;
    end else begin
      check("idle_we", ram_we, 0);
      check("idle_ce", ram_qspo_ce, 0);
    end
    if (!srst_n) begin
      last_ref = 1;
      n0 = 0;
      n1 = 0;
      clr_left = CLR;
      sw_addr = 0;
    end
    rv0 = n0;
    rv1 = n1;
    if (n0) rd0 = nd;
    if (n1) rd1 = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit port, bit req, bit we, int addr, logic [DW-1:0] data);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = AW'(addr); p1_wdata = data;
    end else begin
      p0_req = req; p0_we = we; p0_addr = AW'(addr); p0_wdata = data;
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) mem_ref[i] = init_val(i);
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    srst_n = 0;
    @(posedge clk);
    #1;
    last_ref = 1;
    rv0 = 0;
    rv1 = 0;
    clr_left = CLR;
    sw_addr = 0;
    cycle();
    srst_n = 1;
    drive(0, 1, 0, 5, '0);
    repeat (CLR) cycle();
    cycle();
    drive(0, 0, 0, 0, '0);
    cycle();
    drive(0, 1, 1, 2, 32'h22);
    cycle();
    drive(0, 1, 0, 2, '0);
    cycle();
    drive(0, 0, 0, 0, '0);
    cycle();
    drive(0, 1, 1, 1, 32'd1);
    cycle();
    drive(0, 1, 1, 15, 32'd15);
    cycle();
    drive(0, 1, 0, 1, '0);
    drive(1, 1, 0, 15, '0);
    repeat (4) cycle();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    cycle();
    drive(0, 1, 1, 7, 32'hA);
    drive(1, 1, 1, 7, 32'hB);
    cycle();
    drive(0, 0, 0, 0, '0);
    cycle();
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 7, '0);
    cycle();
    drive(0, 0, 0, 0, '0);
    cycle();
    check("collision_rd", p0_rdata, 32'hB);
    drive(1, 1, 0, 15, '0);
    srst_n = 0;
    cycle();
    srst_n = 1;
    drive(1, 0, 0, 0, '0);
    check("rst_qspo", ram_qspo, 0);
    cycle();
    repeat (CLR) cycle();
    repeat (20) cycle();
    srst_n = 0;
    cycle();
    srst_n = 1;
    repeat (CLR) cycle();
    for (int n = 0; n < 800; n++) begin
      if (!p0_req || g0 || $urandom_range(19) == 0)
        drive(0, $urandom_range(9) < 6, $urandom_range(1), $urandom_range(7), $urandom);
      if (!p1_req || g1 || $urandom_range(19) == 0)
        drive(1, $urandom_range(9) < 6, $urandom_range(1), $urandom_range(7), $urandom);
      srst_n = ($urandom_range(149) != 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
